id_ex_stage: RTL

//  ID/EX pipeline register and operand-forwarding front end for the DLX EX stage.
//  - Latches decoded instruction fields from ID.
//  - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Detects load-use hazards, stalls IF/ID and inserts one bubble.
//  - Drives A, B and Op straight into the ALU.

---
 rtl/dlx_pkg.sv | 57 +++++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: datapath widths, ALU op-codes and the ID/EX latch payload.
package dlx_pkg;

    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned OPW = 5;

    localparam logic [RW-1:0] REG_ZERO = RW'(0);

    localparam logic [OPW-1:0] ALU_AND    = OPW'(0);
    localparam logic [OPW-1:0] ALU_OR     = OPW'(1);
    localparam logic [OPW-1:0] ALU_ADD    = OPW'(2);
    localparam logic [OPW-1:0] ALU_SUB    = OPW'(3);
    localparam logic [OPW-1:0] ALU_XOR    = OPW'(4);
    localparam logic [OPW-1:0] ALU_SLL    = OPW'(5);
    localparam logic [OPW-1:0] ALU_SRL    = OPW'(6);
    localparam logic [OPW-1:0] ALU_SRA    = OPW'(7);
    localparam logic [OPW-1:0] ALU_SLT    = OPW'(8);
    localparam logic [OPW-1:0] ALU_SLTU   = OPW'(9);
    localparam logic [OPW-1:0] ALU_SEQ    = OPW'(10);
    localparam logic [OPW-1:0] ALU_SNE    = OPW'(11);
    localparam logic [OPW-1:0] ALU_LHI    = OPW'(12);
    localparam logic [OPW-1:0] ALU_MUL    = OPW'(13);
    localparam logic [OPW-1:0] ALU_CVTI2F = OPW'(30);
    localparam logic [OPW-1:0] ALU_CVTF2I = OPW'(31);

    // Decoded instruction as held between ID and EX.
    typedef struct packed {
        logic           valid;
        logic [RW-1:0]  rs1;
        logic [RW-1:0]  rs2;
        logic [RW-1:0]  rd;
        logic [DW-1:0]  rs1_data;
        logic [DW-1:0]  rs2_data;
        logic [DW-1:0]  imm;
        logic           use_imm;
        logic [OPW-1:0] alu_op;
        logic           regwrite;
        logic           is_load;
    } id_ex_t;

    // Bubble: no write, no load, r0 sources so forwarding can never match.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:    1'b0,
        rs1:      REG_ZERO,
        rs2:      REG_ZERO,
        rd:       REG_ZERO,
        rs1_data: DW'(0),
        rs2_data: DW'(0),
        imm:      DW'(0),
        use_imm:  1'b0,
        alu_op:   ALU_AND,
        regwrite: 1'b0,
        is_load:  1'b0
    };

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: EX/MEM beats MEM/WB beats the register file.
module fwd_mux
    import dlx_pkg::*;
(
    input  logic [RW-1:0] rs_idx,
    input  logic [DW-1:0] rf_data,
    input  logic [RW-1:0] exmem_rd,
    input  logic          exmem_regwrite,
    input  logic [DW-1:0] exmem_result,
    input  logic [RW-1:0] memwb_rd,
    input  logic          memwb_regwrite,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    always_comb begin
        data = rf_data;
        if (rs_idx == REG_ZERO) begin
            data = DW'(0);
        end else if (exmem_regwrite && (exmem_rd == rs_idx)) begin
            data = exmem_result;
        end else if (memwb_regwrite && (memwb_rd == rs_idx)) begin
            data = memwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch with operand forwarding and load-use stall for the DLX EX stage.
module id_ex_stage
    import dlx_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [RW-1:0]  id_rs1,
    input  logic [RW-1:0]  id_rs2,
    input  logic [RW-1:0]  id_rd,
    input  logic [DW-1:0]  id_rs1_data,
    input  logic [DW-1:0]  id_rs2_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_use_imm,
    input  logic [OPW-1:0] id_alu_op,
    input  logic           id_regwrite,
    input  logic           id_is_load,
    input  logic           flush,
    input  logic           hold,
    input  logic [RW-1:0]  exmem_rd,
    input  logic           exmem_regwrite,
    input  logic [DW-1:0]  exmem_result,
    input  logic [RW-1:0]  memwb_rd,
    input  logic           memwb_regwrite,
    input  logic [DW-1:0]  memwb_data,
    output logic           stall_id,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_A,
    output logic [DW-1:0]  ex_B,
    output logic [OPW-1:0] ex_op,
    output logic [DW-1:0]  ex_store_data,
    output logic [RW-1:0]  ex_rd,
    output logic           ex_regwrite,
    output logic           ex_is_load
);

    id_ex_t        ex_q;
    id_ex_t        ex_d;
    logic          load_use;
    logic [DW-1:0] fwd_rs1;
    logic [DW-1:0] fwd_rs2;

    // Load in EX whose result the ID instruction needs; held off while flushing or frozen.
    always_comb begin
        load_use = ex_q.valid & ex_q.is_load & ex_q.regwrite & (ex_q.rd != REG_ZERO) &
                   id_valid &
                   ((ex_q.rd == id_rs1) | ((ex_q.rd == id_rs2) & ~id_use_imm));
        stall_id = load_use & ~flush & ~hold;

        ex_d = ex_q;
        if (hold) begin
            ex_d = ex_q;
        end else if (flush || stall_id) begin
            ex_d = ID_EX_BUBBLE;
        end else begin
            ex_d = '{
                valid:    id_valid,
                rs1:      id_rs1,
                rs2:      id_rs2,
                rd:       id_rd,
                rs1_data: id_rs1_data,
                rs2_data: id_rs2_data,
                imm:      id_imm,
                use_imm:  id_use_imm,
                alu_op:   id_alu_op,
                regwrite: id_regwrite,
                is_load:  id_is_load
            };
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= ID_EX_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_idx         (ex_q.rs1),
        .rf_data        (ex_q.rs1_data),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_data     (memwb_data),
        .data           (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_idx         (ex_q.rs2),
        .rf_data        (ex_q.rs2_data),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .exmem_result   (exmem_result),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_data     (memwb_data),
        .data           (fwd_rs2)
    );

    assign ex_valid      = ex_q.valid;
    assign ex_A          = fwd_rs1;
    assign ex_B          = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    assign ex_op         = ex_q.alu_op;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_is_load    = ex_q.is_load;

endmodule
